// File: rtl/pwm_pkg.sv
// ============================================================================
// Module      : pwm_pkg
// Description : Shared constants and the PWM level helper for pwm_peripheral.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package pwm_pkg;

    localparam int              PWM_WIDTH       = 8;
    localparam int              CH_COUNT        = 16;
    localparam logic [7:0]      DUTY_FULL       = 8'hFF;
    localparam int              DEFAULT_CLK_DIV = 13;

    // Full-scale duty is forced high so 0xFF gives a true 100 % with no dip at wrap.
    function automatic logic pwm_level_f(input logic [PWM_WIDTH-1:0] cnt,
                                         input logic [PWM_WIDTH-1:0] duty);
        return (duty == DUTY_FULL) ? 1'b1 : (cnt < duty);
    endfunction

endpackage

`default_nettype wire

// File: rtl/pwm_timebase.sv
// ============================================================================
// Module      : pwm_timebase
// Description : Prescaler plus free-running 8-bit PWM counter with wrap strobe.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pwm_timebase
    import pwm_pkg::*;
#(
    parameter int CLK_DIV = DEFAULT_CLK_DIV
) (
    input  logic                 clk,
    input  logic                 rst_n,
    output logic [PWM_WIDTH-1:0] o_cnt,
    output logic                 o_wrap
);

    localparam logic [7:0] c_presc_last = 8'(CLK_DIV - 1);

    logic [7:0]           r_presc;
    logic [PWM_WIDTH-1:0] r_cnt;
    logic                 w_step;

    assign w_step = (r_presc == c_presc_last);
    assign o_cnt  = r_cnt;
    assign o_wrap = w_step && (r_cnt == {PWM_WIDTH{1'b1}});

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_presc <= '0;
            r_cnt   <= '0;
        end else if (w_step) begin
            r_presc <= '0;
            r_cnt   <= r_cnt + 1'b1;
        end else begin
            r_presc <= r_presc + 1'b1;
        end
    end

endmodule

`default_nettype wire

// File: rtl/pwm_peripheral.sv
// ============================================================================
// Module      : pwm_peripheral
// Description : 16-channel static/PWM pin driver with double-buffered duty.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pwm_peripheral
    import pwm_pkg::*;
#(
    parameter int CLK_DIV = DEFAULT_CLK_DIV
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [7:0]          en_reg_out_7_0,
    input  logic [7:0]          en_reg_out_15_8,
    input  logic [7:0]          en_reg_pwm_7_0,
    input  logic [7:0]          en_reg_pwm_15_8,
    input  logic [7:0]          pwm_duty_cycle,
    output logic [CH_COUNT-1:0] out
);

    logic [PWM_WIDTH-1:0] w_cnt;
    logic                 w_wrap;
    logic [PWM_WIDTH-1:0] r_duty_shadow;
    logic                 w_level;
    logic [CH_COUNT-1:0]  w_en_out;
    logic [CH_COUNT-1:0]  w_en_pwm;
    logic [CH_COUNT-1:0]  w_out_next;
    logic [CH_COUNT-1:0]  r_out;

    pwm_timebase #(
        .CLK_DIV (CLK_DIV)
    ) u_timebase (
        .clk    (clk),
        .rst_n  (rst_n),
        .o_cnt  (w_cnt),
        .o_wrap (w_wrap)
    );

    assign w_en_out = {en_reg_out_15_8, en_reg_out_7_0};
    assign w_en_pwm = {en_reg_pwm_15_8, en_reg_pwm_7_0};
    assign w_level  = pwm_level_f(w_cnt, r_duty_shadow);

    // Duty only moves at period start so each period is glitch-free.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_duty_shadow <= '0;
        end else if (w_wrap) begin
            r_duty_shadow <= pwm_duty_cycle;
        end
    end

    generate
        for (genvar i = 0; i < CH_COUNT; i++) begin : g_ch
            assign w_out_next[i] = w_en_out[i] & (w_en_pwm[i] ? w_level : 1'b1);
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out <= '0;
        end else begin
            r_out <= w_out_next;
        end
    end

    assign out = r_out;

endmodule

`default_nettype wire

// File: tb/tb_pwm_peripheral.sv
// ============================================================================
// Module      : tb_pwm_peripheral
// Description : Directed self-checking bench for pwm_peripheral (CLK_DIV=13).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pwm_peripheral;

    localparam int c_div    = 13;
    localparam int c_period = 256 * c_div;

    logic        clk;
    logic        rst_n;
    logic [7:0]  en_reg_out_7_0;
    logic [7:0]  en_reg_out_15_8;
    logic [7:0]  en_reg_pwm_7_0;
    logic [7:0]  en_reg_pwm_15_8;
    logic [7:0]  pwm_duty_cycle;
    logic [15:0] out;

    int n_checks = 0;
    int n_errors = 0;

    logic        mon_en = 1'b0;
    logic [15:0] mon_a  = '0;
    logic [15:0] mon_b  = '0;
    int          mon_bad = 0;

    pwm_peripheral #(
        .CLK_DIV (c_div)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .en_reg_out_7_0  (en_reg_out_7_0),
        .en_reg_out_15_8 (en_reg_out_15_8),
        .en_reg_pwm_7_0  (en_reg_pwm_7_0),
        .en_reg_pwm_15_8 (en_reg_pwm_15_8),
        .pwm_duty_cycle  (pwm_duty_cycle),
        .out             (out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Any value outside the two allowed levels means channels diverged.
    always @(negedge clk) begin
        if (mon_en && out !== mon_a && out !== mon_b) mon_bad++;
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic tick(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_for_out(input logic [15:0] val, input int limit, output int n);
        n = 0;
        while (out !== val && n < limit) begin
            @(posedge clk);
            #1;
            n++;
        end
    endtask

    task automatic set_en(input logic [15:0] eo, input logic [15:0] ep);
        {en_reg_out_15_8, en_reg_out_7_0} = eo;
        {en_reg_pwm_15_8, en_reg_pwm_7_0} = ep;
    endtask

    initial begin
        int n;
        int bad;

        rst_n          = 1'b0;
        pwm_duty_cycle = 8'h00;
        set_en(16'h0000, 16'h0000);
        #3;
        check("reset_out", out, 16'h0000);
        @(negedge clk);
        rst_n = 1'b1;
        tick(5);

        // Static drive and enable dominance
        set_en(16'h00FF, 16'h0000);
        tick(1);
        check("static_00ff", out, 16'h00FF);
        set_en(16'h0000, 16'h0000);
        tick(1);
        check("static_off", out, 16'h0000);
        set_en(16'h0000, 16'hFFFF);
        tick(1);
        check("enable_dominates", out, 16'h0000);
        set_en(16'hFF00, 16'h0F00);
        tick(1);
        check("first_period_zero_duty", out, 16'hF000);

        // Asynchronous reset while PWM output is high
        pwm_duty_cycle = 8'h80;
        set_en(16'hFFFF, 16'hFFFF);
        wait_for_out(16'hFFFF, 8000, n);
        check("pre_reset_timeout", n < 8000, 1);
        tick(100);
        check("pre_reset_high", out, 16'hFFFF);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset", out, 16'h0000);
        tick(3);
        check("reset_held", out, 16'h0000);
        @(negedge clk);
        rst_n = 1'b1;

        // 50 % duty, counting from release
        mon_a = 16'h0000;
        mon_b = 16'hFFFF;
        mon_en = 1'b1;
        wait_for_out(16'hFFFF, 8000, n);
        check("first_rise_after_reset", n, c_period + 1);
        wait_for_out(16'h0000, 8000, n);
        check("half_high", n, 128 * c_div);
        wait_for_out(16'hFFFF, 8000, n);
        check("half_low", n, 128 * c_div);
        mon_en = 1'b0;
        check("half_channels_aligned", mon_bad, 0);

        // Duty 0x00: constant low
        pwm_duty_cycle = 8'h00;
        wait_for_out(16'h0000, 8000, n);
        check("half_high_again", n, 128 * c_div);
        bad = 0;
        for (int k = 0; k < 2 * c_period + 344; k++) begin
            tick(1);
            if (out !== 16'h0000) bad++;
        end
        check("duty00_const_low", bad, 0);

        // Duty 0xFF: constant high across wraps
        pwm_duty_cycle = 8'hFF;
        wait_for_out(16'hFFFF, 8000, n);
        check("dutyff_rise_timeout", n < 8000, 1);
        bad = 0;
        for (int k = 0; k < 2 * c_period + 344; k++) begin
            tick(1);
            if (out !== 16'hFFFF) bad++;
        end
        check("dutyff_const_high", bad, 0);

        // Mid-period duty change 0x40 -> 0xC0 at cnt=0x20
        pwm_duty_cycle = 8'h40;
        wait_for_out(16'h0000, 8000, n);
        check("duty40_fall_timeout", n < 8000, 1);
        wait_for_out(16'hFFFF, 8000, n);
        check("duty40_low", n, 192 * c_div);
        tick(32 * c_div - 1);
        pwm_duty_cycle = 8'hC0;
        wait_for_out(16'h0000, 8000, n);
        check("duty40_high_unaffected", n + 32 * c_div - 1, 64 * c_div);
        wait_for_out(16'hFFFF, 8000, n);
        check("duty40_low_tail", n, 192 * c_div);
        wait_for_out(16'h0000, 8000, n);
        check("dutyc0_high", n, 192 * c_div);

        // Mixed static and PWM channels at 25 %
        pwm_duty_cycle = 8'h40;
        set_en(16'hFFFF, 16'h00F0);
        tick(1);
        check("mixed_static_bits", out, 16'hFF0F);
        mon_a   = 16'hFF0F;
        mon_b   = 16'hFFFF;
        mon_bad = 0;
        mon_en  = 1'b1;
        wait_for_out(16'hFFFF, 8000, n);
        check("mixed_rise_timeout", n < 8000, 1);
        wait_for_out(16'hFF0F, 8000, n);
        check("mixed_high", n, 64 * c_div);
        wait_for_out(16'hFFFF, 8000, n);
        check("mixed_low", n, 192 * c_div);
        mon_en = 1'b0;
        check("mixed_other_bits_steady", mon_bad, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/pwm_peripheral.md
# pwm_peripheral

Sixteen-channel output driver sitting directly downstream of the SPI register-file block. Consumes its five 8-bit configuration registers (output enables, PWM-mode enables, duty cycle) and drives 16 chip output pins as static high/low or as a shared ~3 kHz PWM waveform. Duty-cycle changes are double-buffered so that every PWM period is glitch-free.

## Interface
Parameters:
- CLK_DIV, 13: system clocks per PWM counter step; period = 256·CLK_DIV clocks (10 MHz → ≈3.0 kHz). Legal range 1–255.

Ports:
- clk  input  1  system clock. One clock domain; all logic on its rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- en_reg_out_7_0  input  8  output enable, channels 7:0 (SPI address 0).
- en_reg_out_15_8  input  8  output enable, channels 15:8 (address 1).
- en_reg_pwm_7_0  input  8  PWM-mode select, channels 7:0 (address 2).
- en_reg_pwm_15_8  input  8  PWM-mode select, channels 15:8 (address 3).
- pwm_duty_cycle  input  8  duty, 0x00 = 0 %, 0xFF = 100 % (address 4).
- out  output  16  pin drive, registered.

## Operation
- Inputs are already synchronous to clk (SPI block registers them on clk); no synchronisers here.
- Prescaler: presc counts 0..CLK_DIV-1, wraps to 0; step = (presc == CLK_DIV-1).
- PWM counter: 8-bit cnt increments on step, wraps 255→0 naturally (mod 256).
- Period start: wrap = step && cnt == 255. On wrap, duty_shadow ← pwm_duty_cycle. No other load path.
- PWM level: pwm_level = (duty_shadow == 8'hFF) ? 1 : (cnt < duty_shadow). 0x00 → constant low; 0xFF → constant high (not 255/256).
- Per channel i (en_out = {en_reg_out_15_8, en_reg_out_7_0}, en_pwm likewise):
  - en_out[i]=0 → out[i] ← 0 (enable dominates PWM select).
  - en_out[i]=1, en_pwm[i]=0 → out[i] ← 1.
  - en_out[i]=1, en_pwm[i]=1 → out[i] ← pwm_level.
- All PWM channels share one counter, so they are phase-aligned.
- Simultaneous: enable change on the same cycle as wrap → both take effect; out reflects new enables with new duty_shadow's level for cnt=0.

## Timing
- Reset (async assert, any time incl. mid-period): presc=0, cnt=0, duty_shadow=0x00, out=16'h0000. Release: counting starts on first clk edge after deassertion.
- Consequence: first period after reset is 0 % duty for PWM channels; configured duty appears from the first wrap (256·CLK_DIV clocks after release).
- Enable/PWM-select latency: 1 clock (input change at edge n visible on out after edge n+1).
- Duty latency: takes effect at the next wrap; never within the current period.
- High time per period = duty_shadow·CLK_DIV clocks (duty<0xFF); low time = (256−duty_shadow)·CLK_DIV.
- out edges are registered; out[i] rises one clock after cnt returns to 0 and falls one clock after cnt reaches duty_shadow.

## Structure
- Shared package pwm_pkg: PWM_WIDTH=8, CH_COUNT=16, DUTY_FULL=8'hFF, default CLK_DIV=13.
- One sub-module: pwm_timebase (presc + cnt, outputs cnt[7:0] and wrap). Top holds duty_shadow, level compare, channel mux and out register.

## Test plan
- Reset: assert rst_n=0 mid-period with all enables 0xFF and duty 0x80 → out=0x0000 immediately (asynchronous), cnt restarts at 0 on release.
- Static: en_out=0x00FF, en_pwm=0x0000 → out=0x00FF one clock later; then en_out=0x0000 → out=0x0000 one clock later.
- 50 %: en_out=0xFFFF, en_pwm=0xFFFF, duty 0x80, CLK_DIV=13 → after first wrap, each period 3328 clocks, high exactly 1664, all 16 channels identical.
- Extremes: duty 0x00 → out constant 0x0000; duty 0xFF → constant 0xFFFF across ≥2 periods (no single-clock dip at wrap).
- Mid-period duty change: duty 0x40→0xC0 written at cnt=0x20 → current period high 64·13=832 clocks, next period 192·13=2496.
- Mixed: en_out=0xFFFF, en_pwm=0x00F0, duty 0x40 → bits 7:4 toggle at 25 %, other bits steady high.
